cpu_pc_stack: RTL and testbench

CPU_PC_STACK -- requirements
Module: cpu_pc_stack

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_lifo.sv | 84 ++++++++
 rtl/cpu_pc_stack.sv | 138 +++++++++++++
 tb/tb_cpu_pc_stack.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the program-counter block: the
//               next-PC operation encodings carried on MODE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int MODE_W = 3;

  // Next-PC operation select. The two spare codes are decoded as INC.
  typedef enum logic [MODE_W-1:0] {
    MODE_INC     = 3'b000,
    MODE_HOLD    = 3'b001,
    MODE_JMP_ABS = 3'b010,
    MODE_JMP_REL = 3'b011,
    MODE_CALL    = 3'b100,
    MODE_RET     = 3'b101,
    MODE_RSVD6   = 3'b110,
    MODE_RSVD7   = 3'b111
  } pc_mode_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/cpu_lifo.sv
// ============================================================================
// Module      : cpu_lifo
// Description : Return-address stack (LIFO) with entry count.
//               A push while full and a pop while empty are ignored.
// Ports       : clk_i   - clock, rising edge
//               rst_i   - synchronous active-high reset (clears count only)
//               push_i  - push data_i onto the stack
//               pop_i   - discard the top entry
//               data_i  - value to push
//               top_o   - current top entry (valid when not empty)
//               full_o  - count equals DEPTH
//               empty_o - count equals 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_lifo
  import cpu_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [AWIDTH-1:0] data_i,
  output logic [AWIDTH-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [AWIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  // Next free slot is at index count; the top sits one below it. Subtracting
  // in index width wraps correctly when count equals a power-of-two DEPTH.
  assign wr_idx = count_q[IW-1:0];
  assign rd_idx = wr_idx - IDX_ONE;
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule : cpu_lifo

`default_nettype wire

// File: rtl/cpu_pc_stack.sv
// ============================================================================
// Module      : cpu_pc_stack
// Description : Program counter with CALL/RET return-address stack.
//               Optional sticky overflow/underflow flags are built when the
//               macro CPU_PC_STACK_ERR_EN is defined; otherwise OVF/UDF are 0.
// Ports       : CLK         - clock, rising edge
//               RST         - synchronous active-high reset, highest priority
//               EN          - advance enable; low freezes all state
//               MODE        - next-PC operation (see cpu_pkg)
//               ADDR        - jump target or two's-complement offset
//               PC_OUT      - registered program counter
//               STACK_FULL  - stack holds DEPTH entries
//               STACK_EMPTY - stack holds no entries
//               OVF         - sticky: CALL issued while full
//               UDF         - sticky: RET issued while empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_pc_stack
  import cpu_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [2:0]        MODE,
  input  logic [AWIDTH-1:0] ADDR,
  output logic [AWIDTH-1:0] PC_OUT,
  output logic              STACK_FULL,
  output logic              STACK_EMPTY,
  output logic              OVF,
  output logic              UDF
);

  localparam logic [AWIDTH-1:0] PC_ONE = AWIDTH'(1);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] pc_inc;
  logic [AWIDTH-1:0] lifo_top;
  logic              lifo_full;
  logic              lifo_empty;
  logic              push;
  logic              pop;

  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_HOLD:    pc_d = pc_q;
        MODE_JMP_ABS: pc_d = ADDR;
        // Modular add is the same for signed and unsigned offsets.
        MODE_JMP_REL: pc_d = pc_q + ADDR;
        MODE_CALL: begin
          // The jump is taken even when the push is dropped for a full stack.
          pc_d = ADDR;
          push = !lifo_full;
        end
        MODE_RET: begin
          if (lifo_empty) begin
            pc_d = pc_inc;
          end else begin
            pc_d = lifo_top;
            pop  = 1'b1;
          end
        end
        default:      pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  cpu_lifo #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (lifo_top),
    .full_o  (lifo_full),
    .empty_o (lifo_empty)
  );

  assign PC_OUT      = pc_q;
  assign STACK_FULL  = lifo_full;
  assign STACK_EMPTY = lifo_empty;

`ifdef CPU_PC_STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (EN && (MODE == MODE_CALL) && lifo_full) begin
      ovf_d = 1'b1;
    end
    if (EN && (MODE == MODE_RET) && lifo_empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule : cpu_pc_stack

`default_nettype wire

// File: tb/tb_cpu_pc_stack.sv
// ============================================================================
// Module      : tb_cpu_pc_stack
// Description : Self-checking bench for cpu_pc_stack: directed vector table
//               followed by random operations against a queue-based model.
//               Flag expectations follow CPU_PC_STACK_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_pc_stack;

  localparam int AWIDTH = 8;
  localparam int DEPTH  = 4;
`ifdef CPU_PC_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              EN;
  logic [2:0]        MODE;
  logic [AWIDTH-1:0] ADDR;
  logic [AWIDTH-1:0] PC_OUT;
  logic              STACK_FULL, STACK_EMPTY, OVF, UDF;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cpu_pc_stack #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .MODE        (MODE),
    .ADDR        (ADDR),
    .PC_OUT      (PC_OUT),
    .STACK_FULL  (STACK_FULL),
    .STACK_EMPTY (STACK_EMPTY),
    .OVF         (OVF),
    .UDF         (UDF)
  );

  typedef struct {
    bit       rst;
    bit       en;
    bit [2:0] mode;
    bit [7:0] addr;
    bit [7:0] pc;
    bit       full;
    bit       empty;
    bit       ovf;
    bit       udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit en, bit [2:0] mode, bit [7:0] addr,
                              bit [7:0] pc, bit full, bit empty, bit ovf, bit udf);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.addr = addr;
    v.pc = pc; v.full = full; v.empty = empty; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic compare(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h full=%b empty=%b ovf=%b udf=%b, expected pc=%h full=%b empty=%b ovf=%b udf=%b",
               name, act[11:4], act[3], act[2], act[1], act[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(bit rst, bit en, bit [2:0] mode, bit [7:0] addr);
    RST  = rst;
    EN   = en;
    MODE = mode;
    ADDR = addr;
    @(posedge CLK);
    #1;
  endtask

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  bit         m_ovf, m_udf;

  task automatic model_step(bit rst, bit en, bit [2:0] mode, bit [7:0] addr);
    if (rst) begin
      m_pc = 8'h00;
      m_stack.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (en) begin
      case (mode)
        3'd1: ;
        3'd2: m_pc = addr;
        3'd3: m_pc = m_pc + addr;
        3'd4: begin
          if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 8'd1);
          else if (ERR) m_ovf = 1'b1;
          m_pc = addr;
        end
        3'd5: begin
          if (m_stack.size() == 0) begin
            m_pc = m_pc + 8'd1;
            if (ERR) m_udf = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; MODE = 3'd0; ADDR = 8'h00;

    //            rst en mode  addr    pc    full empty ovf  udf
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 8'h00, 0, 1, 0,   0));   // reset
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 8'h01, 0, 1, 0,   0));   // INC
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 8'h02, 0, 1, 0,   0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 8'h03, 0, 1, 0,   0));
    vecs.push_back(mk(0, 0, 3'd2, 8'h55, 8'h03, 0, 1, 0,   0));   // EN=0 holds
    vecs.push_back(mk(0, 0, 3'd4, 8'h66, 8'h03, 0, 1, 0,   0));
    vecs.push_back(mk(0, 1, 3'd2, 8'h10, 8'h10, 0, 1, 0,   0));   // JMP_ABS
    vecs.push_back(mk(0, 1, 3'd3, 8'hFC, 8'h0C, 0, 1, 0,   0));   // JMP_REL -4
    vecs.push_back(mk(0, 1, 3'd2, 8'hFF, 8'hFF, 0, 1, 0,   0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 8'h00, 0, 1, 0,   0));   // INC wraps
    vecs.push_back(mk(0, 1, 3'd2, 8'h05, 8'h05, 0, 1, 0,   0));
    vecs.push_back(mk(0, 1, 3'd4, 8'h40, 8'h40, 0, 0, 0,   0));   // CALL
    vecs.push_back(mk(0, 1, 3'd5, 8'h99, 8'h06, 0, 1, 0,   0));   // RET
    vecs.push_back(mk(0, 1, 3'd1, 8'h12, 8'h06, 0, 1, 0,   0));   // HOLD
    vecs.push_back(mk(0, 1, 3'd6, 8'h12, 8'h07, 0, 1, 0,   0));   // spare = INC
    vecs.push_back(mk(0, 1, 3'd7, 8'h12, 8'h08, 0, 1, 0,   0));
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 8'h80, 0, 0, 0,   0));   // push 09
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 8'h80, 0, 0, 0,   0));   // push 81
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 8'h80, 0, 0, 0,   0));   // push 81
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 8'h80, 1, 0, 0,   0));   // push 81 -> full
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 8'h80, 1, 0, ERR, 0));   // overflow
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 8'h81, 0, 0, ERR, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 8'h81, 0, 0, ERR, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 8'h81, 0, 0, ERR, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 8'h09, 0, 1, ERR, 0));
    vecs.push_back(mk(0, 1, 3'd2, 8'h20, 8'h20, 0, 1, ERR, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 8'h21, 0, 1, ERR, ERR)); // underflow
    vecs.push_back(mk(0, 0, 3'd5, 8'h00, 8'h21, 0, 1, ERR, ERR));
    vecs.push_back(mk(1, 1, 3'd4, 8'h77, 8'h00, 0, 1, 0,   0));   // RST beats CALL
    vecs.push_back(mk(0, 1, 3'd4, 8'h33, 8'h33, 0, 0, 0,   0));
    vecs.push_back(mk(1, 1, 3'd5, 8'h00, 8'h00, 0, 1, 0,   0));   // RST beats RET

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].addr);
      compare($sformatf("vec%0d", i),
              {PC_OUT, STACK_FULL, STACK_EMPTY, OVF, UDF},
              {vecs[i].pc, vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].udf});
    end

    // Random operations against the model, starting from reset.
    m_pc = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit       r_rst, r_en;
      bit [2:0] r_mode;
      bit [7:0] r_addr;
      r_rst  = (i == 0) || ($urandom_range(0, 49) == 0);
      r_en   = ($urandom_range(0, 9) != 0);
      r_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) r_mode = 3'($urandom_range(4, 5));
      r_addr = 8'($urandom);
      step(r_rst, r_en, r_mode, r_addr);
      model_step(r_rst, r_en, r_mode, r_addr);
      compare($sformatf("rand%0d", i),
              {PC_OUT, STACK_FULL, STACK_EMPTY, OVF, UDF},
              {m_pc, m_stack.size() == DEPTH, m_stack.size() == 0, m_ovf, m_udf});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cpu_pc_stack

`default_nettype wire
